// File: rtl/joybus_tx_if.sv
// joybus_tx_if: byte-stream valid/ready handshake feeding the Joybus transmitter.
// master: producer drives in_data/in_valid; slave: transmitter drives in_ready.
interface joybus_tx_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/joybus_tx.sv
// joybus_tx: length-driven Joybus controller-side transmitter, MSB first, stop bit last.
// Ports: sample_clk, reset_n, start/len/append_crc request, in_if byte stream (slave),
// data_tx wire level, busy, done pulse, err (valid with done).
// Optional CRC-8 trailer (poly 0x85) built when JOYBUS_TX_CRC_EN is defined.
module joybus_tx #(
    parameter int LEVEL_WIDTH = 2,
    parameter int MAX_BYTES   = 33,
    parameter int LEN_W       = $clog2(MAX_BYTES + 1)
) (
    input  logic             sample_clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             append_crc,
    joybus_tx_if.slave       in_if,
    output logic             data_tx,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam int BIT_WIDTH = 4 * LEVEL_WIDTH;
    localparam int LVL_W     = $clog2(BIT_WIDTH);

    localparam logic [LVL_W-1:0] LVL_LAST = LVL_W'(BIT_WIDTH - 1);
    localparam logic [LVL_W-1:0] LVL_Q1   = LVL_W'(LEVEL_WIDTH);
    localparam logic [LVL_W-1:0] LVL_Q2   = LVL_W'(2 * LEVEL_WIDTH);
    localparam logic [LVL_W-1:0] LVL_Q3   = LVL_W'(3 * LEVEL_WIDTH);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_BYTES);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_CRC  = 3'd3;
    localparam logic [2:0] S_STOP = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [LVL_W-1:0] lvl_q, lvl_d;
    logic [2:0]       bit_q, bit_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_vld_q, hold_vld_d;
    logic [7:0]       shift_q, shift_d;
    logic             err_q, err_d;

    logic             fire;
    logic             load_byte;
    logic             have_byte;
    logic             bit_end;
    logic             more;
    logic             is_stop;
    logic [7:0]       next_byte;
    logic [LVL_W-1:0] lvl_inc;

`ifdef JOYBUS_TX_CRC_EN
    logic       crc_en_q, crc_en_d;
    logic [7:0] crc_q, crc_d, crc_nxt;

    // One CRC step over the bit currently on the wire.
    assign crc_nxt = {crc_q[6:0], 1'b0}
                   ^ ((crc_q[7] ^ shift_q[7]) ? 8'h85 : 8'h00);
`else
    logic unused_append_crc;
    assign unused_append_crc = append_crc;
`endif

    assign in_if.in_ready = (state_q == S_LOAD || state_q == S_DATA)
                          && !hold_vld_q && (cnt_q < len_q);

    assign fire    = in_if.in_valid && in_if.in_ready;
    // A byte arriving on the very boundary cycle bypasses the holding register.
    assign have_byte = hold_vld_q || fire;
    assign next_byte = hold_vld_q ? hold_q : in_if.in_data;
    assign more      = cnt_q < len_q;
    assign bit_end   = lvl_q == LVL_LAST;
    assign lvl_inc   = bit_end ? '0 : lvl_q + 1'b1;
    assign is_stop   = state_q == S_STOP;

    assign busy = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done = state_q == S_DONE;
    assign err  = done && err_q;

    always_comb begin
        data_tx = 1'b1;
        if (state_q == S_DATA || state_q == S_CRC || is_stop) begin
            if (lvl_q < LVL_Q1)
                data_tx = 1'b0;
            else if (lvl_q < LVL_Q2)
                data_tx = !is_stop && shift_q[7];
            else if (lvl_q < LVL_Q3)
                data_tx = is_stop || shift_q[7];
        end
    end

    always_comb begin
        state_d    = state_q;
        lvl_d      = lvl_q;
        bit_d      = bit_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        shift_d    = shift_q;
        err_d      = err_q;
        load_byte  = 1'b0;
`ifdef JOYBUS_TX_CRC_EN
        crc_en_d   = crc_en_q;
        crc_d      = crc_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    lvl_d      = '0;
                    bit_d      = '0;
                    cnt_d      = '0;
                    hold_vld_d = 1'b0;
                    if (len > LEN_MAX) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                        len_d   = len;
                        err_d   = 1'b0;
`ifdef JOYBUS_TX_CRC_EN
                        crc_en_d = append_crc;
                        crc_d    = 8'h00;
`endif
                    end
                end
            end
            S_LOAD: begin
                if (len_q == '0) begin
                    state_d = S_STOP;
`ifdef JOYBUS_TX_CRC_EN
                    if (crc_en_q) begin
                        state_d = S_CRC;
                        shift_d = crc_q;
                    end
`endif
                end else if (have_byte) begin
                    state_d   = S_DATA;
                    load_byte = 1'b1;
                end
            end
            S_DATA: begin
                lvl_d = lvl_inc;
                if (bit_end) begin
                    shift_d = {shift_q[6:0], 1'b0};
                    bit_d   = bit_q + 3'd1;
`ifdef JOYBUS_TX_CRC_EN
                    crc_d   = crc_nxt;
`endif
                    if (bit_q == 3'd7) begin
                        if (have_byte) begin
                            load_byte = 1'b1;
                        end else if (more) begin
                            // Underrun: stop bit replaces the missing byte.
                            state_d = S_STOP;
                            err_d   = 1'b1;
                        end else begin
                            state_d = S_STOP;
`ifdef JOYBUS_TX_CRC_EN
                            if (crc_en_q) begin
                                state_d = S_CRC;
                                shift_d = crc_nxt;
                            end
`endif
                        end
                    end
                end
            end
            S_CRC: begin
                lvl_d = lvl_inc;
                if (bit_end) begin
                    shift_d = {shift_q[6:0], 1'b0};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7)
                        state_d = S_STOP;
                end
            end
            S_STOP: begin
                lvl_d = lvl_inc;
                if (bit_end)
                    state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load_byte) begin
            shift_d    = next_byte;
            hold_vld_d = 1'b0;
        end
        if (fire && !load_byte) begin
            hold_d     = in_if.in_data;
            hold_vld_d = 1'b1;
        end
        if (fire)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge sample_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            lvl_q      <= '0;
            bit_q      <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            shift_q    <= '0;
            err_q      <= 1'b0;
`ifdef JOYBUS_TX_CRC_EN
            crc_en_q   <= 1'b0;
            crc_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            lvl_q      <= lvl_d;
            bit_q      <= bit_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            shift_q    <= shift_d;
            err_q      <= err_d;
`ifdef JOYBUS_TX_CRC_EN
            crc_en_q   <= crc_en_d;
            crc_q      <= crc_d;
`endif
        end
    end
endmodule

// File: tb/tb_joybus_tx.sv
// tb_joybus_tx: table-driven frames with a symbol scoreboard for joybus_tx,
// plus hand sequences for bad length and mid-frame reset.
module tb_joybus_tx;
    localparam int LW    = 2;
    localparam int MAXB  = 33;
    localparam int LEN_W = $clog2(MAXB + 1);
    localparam int BW    = 4 * LW;
`ifdef JOYBUS_TX_CRC_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             append_crc;
    logic             data_tx;
    logic             busy;
    logic             done;
    logic             err;

    joybus_tx_if bus();

    joybus_tx #(
        .LEVEL_WIDTH(LW),
        .MAX_BYTES  (MAXB)
    ) dut (
        .sample_clk(clk),
        .reset_n   (rst_n),
        .start     (start),
        .len       (len),
        .append_crc(append_crc),
        .in_if     (bus),
        .data_tx   (data_tx),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        int         len;
        bit         crc;
        int         nfirst;
        int         gap;
        int         offer;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        bit         exp_err;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   exp_q[$];
    int   accepted;
    bit   mon_done;
    vec_t vecs[9];
    vec_t vrst;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input string n, input int l, input bit c,
                                input int nf, input int g, input int off,
                                input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] d, input bit e);
        vec_t v;
        v.name = n; v.len = l; v.crc = c; v.nfirst = nf; v.gap = g;
        v.offer = off; v.b0 = a; v.b1 = b; v.b2 = d; v.exp_err = e;
        return v;
    endfunction

    function automatic logic [7:0] byte_val(input vec_t v, input int i);
        if (i == 0) return v.b0;
        if (i == 1) return v.b1;
        if (i == 2) return v.b2;
        return 8'(i * 37 + 11);
    endfunction

    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
        logic fb;
        fb = c[7] ^ b;
        return {c[6:0], 1'b0} ^ (fb ? 8'h85 : 8'h00);
    endfunction

    // Time-ordered wire waveform of one symbol: 0, 1 or 2 (stop).
    function automatic logic [BW-1:0] sym_wave(input int s);
        logic [3:0]    p;
        logic [BW-1:0] w;
        p = (s == 2) ? 4'b0011 : (s == 1) ? 4'b0111 : 4'b0001;
        w = '0;
        for (int q = 0; q < 4; q++)
            for (int c = 0; c < LW; c++)
                w = {w[BW-2:0], p[3-q]};
        return w;
    endfunction

    task automatic produce(input vec_t v);
        int i;
        int wait_c;
        int budget;
        bit f;
        i = 0;
        wait_c = 0;
        budget = 4000;
        bus.in_valid = (v.offer > 0);
        bus.in_data  = byte_val(v, 0);
        while (!mon_done && budget > 0) begin
            @(negedge clk);
            f = bus.in_valid && bus.in_ready;
            tick();
            budget--;
            if (f) begin
                accepted++;
                i++;
                if (i == v.nfirst) wait_c = v.gap;
            end
            if (wait_c > 0) begin
                wait_c--;
                bus.in_valid = 1'b0;
            end else begin
                bus.in_valid = (i < v.offer);
            end
            bus.in_data = byte_val(v, i);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic run_mon(input vec_t v, input int nsym);
        int            k;
        bit            seen;
        int            s;
        logic          wv[$];
        logic [BW-1:0] got;
        start      = 1'b1;
        len        = LEN_W'(v.len);
        append_crc = v.crc;
        tick();
        start = 1'b0;
        k = 1;
        while (data_tx !== 1'b0 && k < 20) begin
            tick();
            k++;
        end
        check({v.name, " first_low"}, k, 2);
        check({v.name, " busy"}, busy, 1'b1);
        seen = 1'b0;
        for (int c = 0; c < nsym * BW + 20; c++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            wv.push_back(data_tx);
            tick();
        end
        check({v.name, " done_seen"}, seen, 1'b1);
        check({v.name, " frame_len"}, wv.size(), nsym * BW);
        check({v.name, " err"}, err, v.exp_err);
        check({v.name, " busy_done"}, busy, 1'b0);
        check({v.name, " tx_done"}, data_tx, 1'b1);
        for (int n = 0; n < nsym; n++) begin
            s = exp_q.pop_front();
            got = '0;
            for (int c = 0; c < BW; c++)
                got = {got[BW-2:0],
                       (n * BW + c < wv.size()) ? wv[n * BW + c] : 1'bx};
            check($sformatf("%s sym%0d", v.name, n), got, sym_wave(s));
        end
        tick();
        check({v.name, " done_pulse"}, done, 1'b0);
        check({v.name, " tx_idle"}, data_tx, 1'b1);
        mon_done = 1'b1;
    endtask

    task automatic run_frame(input vec_t v);
        int         nsent;
        int         nsym;
        logic [7:0] crc;
        logic [7:0] b;
        nsent = v.exp_err ? v.nfirst : v.len;
        crc = 8'h00;
        for (int i = 0; i < nsent; i++) begin
            b = byte_val(v, i);
            for (int j = 7; j >= 0; j--) begin
                exp_q.push_back(int'(b[j]));
                crc = crc_step(crc, b[j]);
            end
        end
        if (v.crc && CRC_ON && !v.exp_err)
            for (int j = 7; j >= 0; j--)
                exp_q.push_back(int'(crc[j]));
        exp_q.push_back(2);
        nsym = exp_q.size();
        accepted = 0;
        mon_done = 1'b0;
        fork
            produce(v);
            run_mon(v, nsym);
        join
        check({v.name, " accepted"}, accepted, nsent);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hi;
        int k;
        vecs[0] = mk("b050000",   3,    1'b0, 3, 0,  3,    8'h05, 8'h00, 8'h00, 1'b0);
        vecs[1] = mk("ff",        1,    1'b0, 1, 0,  1,    8'hFF, 8'h00, 8'h00, 1'b0);
        vecs[2] = mk("crc01",     1,    1'b1, 1, 0,  1,    8'h01, 8'h00, 8'h00, 1'b0);
        vecs[3] = mk("underrun",  2,    1'b0, 1, 67, 2,    8'hA5, 8'h5A, 8'h00, 1'b1);
        vecs[4] = mk("len0",      0,    1'b1, 0, 0,  0,    8'h00, 8'h00, 8'h00, 1'b0);
        vecs[5] = mk("stall",     3,    1'b0, 1, 30, 3,    8'hA5, 8'h3C, 8'h81, 1'b0);
        vecs[6] = mk("beyond",    2,    1'b0, 2, 0,  4,    8'hC3, 8'h96, 8'h77, 1'b0);
        vecs[7] = mk("max",       MAXB, 1'b1, MAXB, 0, MAXB, 8'hDE, 8'hAD, 8'hBE, 1'b0);
        vecs[8] = mk("crc2",      2,    1'b1, 2, 0,  2,    8'h12, 8'h34, 8'h00, 1'b0);
        vrst    = mk("after_rst", 1,    1'b0, 1, 0,  1,    8'h3C, 8'h00, 8'h00, 1'b0);

        rst_n        = 1'b0;
        start        = 1'b0;
        len          = '0;
        append_crc   = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) tick();
        check("rst data_tx", data_tx, 1'b1);
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst err", err, 1'b0);
        check("rst in_ready", bus.in_ready, 1'b0);
        rst_n = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 9; i++) begin
            run_frame(vecs[i]);
            repeat (3) tick();
        end

        start = 1'b1;
        len   = LEN_W'(MAXB + 1);
        tick();
        start = 1'b0;
        check("badlen done", done, 1'b1);
        check("badlen err", err, 1'b1);
        check("badlen busy", busy, 1'b0);
        hi = data_tx;
        tick();
        check("badlen done_pulse", done, 1'b0);
        for (int c = 0; c < 10; c++) begin
            hi &= data_tx & !busy;
            tick();
        end
        check("badlen tx_high", hi, 1'b1);

        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAA;
        start        = 1'b1;
        len          = LEN_W'(1);
        append_crc   = 1'b0;
        tick();
        start = 1'b0;
        k = 1;
        while (data_tx !== 1'b0 && k < 20) begin
            tick();
            k++;
        end
        bus.in_valid = 1'b0;
        repeat (8) tick();
        check("midrst pre_low", data_tx, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check("midrst data_tx", data_tx, 1'b1);
        check("midrst busy", busy, 1'b0);
        check("midrst in_ready", bus.in_ready, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        run_frame(vrst);
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
